// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: parametrised VGA timing generator with a request-ahead pixel
// interface and an output stage aligned to a PIX_LAT-cycle pixel source.
module vga_timing_pipe #(
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_ACT   = 480,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned COLOR_W = 10,
    parameter int unsigned PIX_LAT = 2
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEN,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [10:0]        oCurrent_X,
    output logic [10:0]        oCurrent_Y,
    output logic               oFrame_Start,
    output logic               oLine_Start,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int unsigned H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACT;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACT;

    localparam logic [10:0] H_BLANK_C  = 11'(H_BLANK);
    localparam logic [10:0] V_BLANK_C  = 11'(V_BLANK);
    localparam logic [10:0] H_LAST_C   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST_C   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_BEG_C   = 11'(H_FRONT);
    localparam logic [10:0] HS_END_C   = 11'(H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG_C   = 11'(V_FRONT);
    localparam logic [10:0] VS_END_C   = 11'(V_FRONT + V_SYNC);

    if (PIX_LAT > 15 || H_TOTAL > 2047 || V_TOTAL > 2047) begin : gBadParam
        $error("vga_timing_pipe: PIX_LAT must be 0..15 and H_TOTAL/V_TOTAL <= 2047");
    end

    logic [10:0] hCnt, vCnt;
    logic        act, hsRaw, vsRaw;
    logic        actD, hsD, vsD;

    // Pixel/line counters; iEN=0 freezes them
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (iEN) begin
            if (hCnt == H_LAST_C) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST_C) ? '0 : vCnt + 11'd1;
            end else begin
                hCnt <= hCnt + 11'd1;
            end
        end
    end

    // Raw timing decode and zero-latency request interface
    always_comb begin
        act          = (hCnt >= H_BLANK_C) && (vCnt >= V_BLANK_C);
        hsRaw        = (hCnt >= HS_BEG_C) && (hCnt < HS_END_C);
        vsRaw        = (vCnt >= VS_BEG_C) && (vCnt < VS_END_C);
        oRequest     = act;
        oCurrent_X   = act ? hCnt - H_BLANK_C : '0;
        oCurrent_Y   = act ? vCnt - V_BLANK_C : '0;
        oLine_Start  = act && (hCnt == H_BLANK_C);
        oFrame_Start = act && (hCnt == H_BLANK_C) && (vCnt == V_BLANK_C);
        oVGA_SYNC    = 1'b1;
        oVGA_CLOCK   = ~iCLK;
    end

    if (PIX_LAT == 0) begin : gNoDly
        // No pixel-source latency: output register samples raw timing directly
        always_comb begin
            actD = act;
            hsD  = hsRaw;
            vsD  = vsRaw;
        end
    end else begin : gDly
        logic [2:0] stage [PIX_LAT];

        // Delay {act,hs,vs} by PIX_LAT cycles to match the returned colour
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                for (int unsigned i = 0; i < PIX_LAT; i++) stage[i] <= '0;
            end else if (iEN) begin
                stage[0] <= {act, hsRaw, vsRaw};
                for (int unsigned i = 1; i < PIX_LAT; i++) stage[i] <= stage[i-1];
            end
        end

        // Tap the last delay stage
        always_comb begin
            actD = stage[PIX_LAT-1][2];
            hsD  = stage[PIX_LAT-1][1];
            vsD  = stage[PIX_LAT-1][0];
        end
    end

    // DAC output register: colour blanked outside active, polarity applied to syncs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R     <= '0;
            oVGA_G     <= '0;
            oVGA_B     <= '0;
            oVGA_BLANK <= 1'b0;
            oVGA_HS    <= ~HS_POL;
            oVGA_VS    <= ~VS_POL;
        end else if (iEN) begin
            oVGA_R     <= actD ? iRed   : '0;
            oVGA_G     <= actD ? iGreen : '0;
            oVGA_B     <= actD ? iBlue  : '0;
            oVGA_BLANK <= actD;
            oVGA_HS    <= hsD ? HS_POL : ~HS_POL;
            oVGA_VS    <= vsD ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: directed checks of a small-geometry vga_timing_pipe
// (8x4 active, all porches/syncs 2, positive syncs, PIX_LAT=2: 14x10 totals).
module tb_vga_timing_pipe;

    logic        iCLK = 1'b0;
    logic        iRST_N, iEN;
    logic [9:0]  iRed, iGreen, iBlue;
    logic        oRequest, oFrame_Start, oLine_Start;
    logic [10:0] oCurrent_X, oCurrent_Y;
    logic [9:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    logic [10:0] p1 = '0, p2 = '0;

    vga_timing_pipe #(
        .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .H_ACT(8),
        .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .V_ACT(4),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(10), .PIX_LAT(2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oRequest(oRequest), .oCurrent_X(oCurrent_X), .oCurrent_Y(oCurrent_Y),
        .oFrame_Start(oFrame_Start), .oLine_Start(oLine_Start),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK(oVGA_BLANK),
        .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int k; bit req; int x; int y; bit fs; bit ls;
        bit hs; bit vs; bit blank; int r;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0d want=%0d", nm, k, act, exp);
        end
    endtask

    // Pixel source model: returns colour for the X requested two enabled cycles earlier
    task automatic step();
        logic [10:0] cx;
        logic en;
        cx = oCurrent_X;
        en = iEN;
        @(posedge iCLK);
        #1;
        if (en) begin
            p2 = p1;
            p1 = cx;
        end
        iRed = 10'(p2) + 10'd100;
    endtask

    task automatic chkVec(input vec_t e);
        chk("req",   int'(oRequest),     int'(e.req));
        chk("x",     int'(oCurrent_X),   e.x);
        chk("y",     int'(oCurrent_Y),   e.y);
        chk("fs",    int'(oFrame_Start), int'(e.fs));
        chk("ls",    int'(oLine_Start),  int'(e.ls));
        chk("hs",    int'(oVGA_HS),      int'(e.hs));
        chk("vs",    int'(oVGA_VS),      int'(e.vs));
        chk("blank", int'(oVGA_BLANK),   int'(e.blank));
        chk("r",     int'(oVGA_R),       e.r);
        chk("g",     int'(oVGA_G),       e.blank ? 'h155 : 0);
        chk("b",     int'(oVGA_B),       e.blank ? 'h2AA : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d got=timeout want=finish", k);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int reqCnt, fsCnt;
        //            k    req x  y  fs ls  hs vs blank r
        tbl[0]  = '{  0,   0, 0, 0, 0, 0,  0, 0, 0,   0};
        tbl[1]  = '{  5,   0, 0, 0, 0, 0,  1, 0, 0,   0};
        tbl[2]  = '{  6,   0, 0, 0, 0, 0,  1, 0, 0,   0};
        tbl[3]  = '{  7,   0, 0, 0, 0, 0,  0, 0, 0,   0};
        tbl[4]  = '{ 33,   0, 0, 0, 0, 0,  1, 1, 0,   0};
        tbl[5]  = '{ 90,   1, 0, 0, 1, 1,  1, 0, 0,   0};
        tbl[6]  = '{ 93,   1, 3, 0, 0, 0,  0, 0, 1, 100};
        tbl[7]  = '{ 96,   1, 6, 0, 0, 0,  0, 0, 1, 103};
        tbl[8]  = '{ 97,   1, 7, 0, 0, 0,  0, 0, 1, 104};
        tbl[9]  = '{ 98,   0, 0, 0, 0, 0,  0, 0, 1, 105};
        tbl[10] = '{100,   0, 0, 0, 0, 0,  0, 0, 1, 107};
        tbl[11] = '{101,   0, 0, 0, 0, 0,  0, 0, 0,   0};
        tbl[12] = '{104,   1, 0, 1, 0, 1,  1, 0, 0,   0};
        tbl[13] = '{139,   1, 7, 3, 0, 0,  0, 0, 1, 104};
        tbl[14] = '{140,   0, 0, 0, 0, 0,  0, 0, 1, 105};
        tbl[15] = '{146,   0, 0, 0, 0, 0,  1, 0, 0,   0};
        tbl[16] = '{230,   1, 0, 0, 1, 1,  1, 0, 0,   0};
        tbl[17] = '{234,   1, 4, 0, 0, 0,  0, 0, 1, 101};

        iRST_N = 1'b0;
        iEN    = 1'b1;
        iRed   = 10'd100;
        iGreen = 10'h155;
        iBlue  = 10'h2AA;
        reqCnt = 0;
        fsCnt  = 0;

        #22 iRST_N = 1'b1;
        #1;
        chk("sync_const", int'(oVGA_SYNC), 1);

        // Free-running table sweep: k counts enabled clock edges since release
        for (k = 0; k <= 234; k++) begin
            if (k > 0) begin
                step();
                @(negedge iCLK);
            end
            if (k < 140) begin
                reqCnt += int'(oRequest);
                fsCnt  += int'(oFrame_Start);
            end
            if (k == 139) begin
                chk("req_per_frame", reqCnt, 32);
                chk("fs_per_frame",  fsCnt, 1);
            end
            foreach (tbl[i]) if (tbl[i].k == k) chkVec(tbl[i]);
        end
        k = 234;

        // Stall mid-line for 5 clocks: everything holds
        iEN = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            @(negedge iCLK);
            chk("stall_x",     int'(oCurrent_X), 4);
            chk("stall_r",     int'(oVGA_R),     101);
            chk("stall_blank", int'(oVGA_BLANK), 1);
            chk("stall_req",   int'(oRequest),   1);
        end
        iEN = 1'b1;
        step();
        @(negedge iCLK);
        k = 235;
        chk("resume_x", int'(oCurrent_X), 5);
        chk("resume_r", int'(oVGA_R),     102);
        step();
        @(negedge iCLK);
        k = 236;
        chk("resume_x2", int'(oCurrent_X), 6);
        chk("resume_r2", int'(oVGA_R),     103);

        // Asynchronous reset mid-active-line, away from any clock edge
        #2 iRST_N = 1'b0;
        #1;
        chk("rst_req",   int'(oRequest),   0);
        chk("rst_x",     int'(oCurrent_X), 0);
        chk("rst_blank", int'(oVGA_BLANK), 0);
        chk("rst_r",     int'(oVGA_R),     0);
        chk("rst_g",     int'(oVGA_G),     0);
        chk("rst_hs",    int'(oVGA_HS),    0);
        chk("rst_vs",    int'(oVGA_VS),    0);
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        p1 = '0;
        p2 = '0;
        iRed = 10'd100;
        #2 iRST_N = 1'b1;
        #1;
        k = 0;
        chk("restart_req", int'(oRequest), 0);
        for (k = 1; k <= 90; k++) begin
            step();
            @(negedge iCLK);
            if (k == 5) chk("restart_hs", int'(oVGA_HS), 1);
        end
        k = 90;
        chk("restart_fs", int'(oFrame_Start), 1);
        chk("restart_x",  int'(oCurrent_X),   0);
        chk("restart_y",  int'(oCurrent_Y),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
